// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: full-wave rectifier, 3-stage CIC decimator by R, optional first-order DC removal.
// Latency: val_out rises 6 clock edges after the edge that samples the R-th valid input of a block.
// Backpressure: none; every stage advances only on its incoming valid bit, so input gaps simply stall the chain.
module am_envelope_demod #(
    parameter int R    = 16,
    parameter int N    = 3,
    parameter int Win  = 14,
    parameter int Wacc = Win + N * $clog2(R),
    parameter int Wout = 16,
    parameter int K    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [Win-1:0]  i_data,
    input  logic                   val_in,
    input  logic                   c_dc_en,
    output logic signed [Wout-1:0] o_data,
    output logic signed [Wout-1:0] o_level,
    output logic                   val_out
);

    localparam int CW = $clog2(R);
    localparam int LW = Wacc - Wout;   // comb bits dropped by the output truncation
    localparam logic [CW-1:0]          CNT_LAST = CW'(R - 1);
    localparam logic signed [Win-1:0]  IN_MIN   = {1'b1, {(Win-1){1'b0}}};
    localparam logic signed [Win-1:0]  IN_MAX   = {1'b0, {(Win-1){1'b1}}};
    localparam logic signed [Wout-1:0] OUT_MIN  = {1'b1, {(Wout-1){1'b0}}};
    localparam logic signed [Wout-1:0] OUT_MAX  = {1'b0, {(Wout-1){1'b1}}};

    // input capture
    logic signed [Win-1:0]  in_q;
    logic                   in_vld;
    // rectifier
    logic [Win-1:0]         rect;
    logic [Win-1:0]         rect_nxt;
    logic                   rect_vld;
    // integrators
    logic [Wacc-1:0]        i1, i2, i3;
    logic                   i1_vld, i2_vld, i3_vld;
    // decimation and comb
    logic [CW-1:0]          cnt;
    logic                   comb_fire;
    logic [Wacc-1:0]        d1, d2, d3;
    logic [Wacc-1:0]        c1, c2;
    logic                   c3_borrow;
    logic signed [Wout-1:0] y_nxt;
    logic signed [Wout-1:0] y;
    logic                   y_vld;
    // DC removal
    logic signed [Wout+K-1:0] acc;
    logic signed [Wout-1:0]   dc;
    logic signed [Wout:0]     diff;
    logic signed [Wout-1:0]   diff_sat;

    // Register the raw sample so the rectifier works from a clean flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q   <= '0;
            in_vld <= 1'b0;
        end else begin
            in_vld <= val_in;
            if (val_in) in_q <= i_data;
        end
    end

    // Absolute value; the most negative code has no positive twin, so clamp it.
    always_comb begin
        rect_nxt = in_q;
        if (in_q[Win-1]) begin
            if (in_q == IN_MIN) rect_nxt = IN_MAX;
            else                rect_nxt = -in_q;
        end
    end

    // Rectifier register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rect     <= '0;
            rect_vld <= 1'b0;
        end else begin
            rect_vld <= in_vld;
            if (in_vld) rect <= rect_nxt;
        end
    end

    // Integrator cascade; modular wrap is harmless because the comb differences it back out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1     <= '0;
            i2     <= '0;
            i3     <= '0;
            i1_vld <= 1'b0;
            i2_vld <= 1'b0;
            i3_vld <= 1'b0;
        end else begin
            i1_vld <= rect_vld;
            i2_vld <= i1_vld;
            i3_vld <= i2_vld;
            if (rect_vld) i1 <= i1 + {{(Wacc-Win){1'b0}}, rect};
            if (i1_vld)   i2 <= i2 + i1;
            if (i2_vld)   i3 <= i3 + i2;
        end
    end

    assign comb_fire = i3_vld && (cnt == CNT_LAST);
    assign c1        = i3 - d1;
    assign c2        = c1 - d2;
    // Only the top Wout bits of c3 = c2 - d3 are kept: form them as a difference of
    // the upper slices minus the borrow out of the dropped lower slices.
    assign c3_borrow = c2[LW-1:0] < d3[LW-1:0];
    assign y_nxt     = c2[Wacc-1:LW] - d3[Wacc-1:LW] - {{(Wout-1){1'b0}}, c3_borrow};

    // Decimation counter and comb section, run once per R integrator outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= comb_fire;
            if (i3_vld) cnt <= cnt + CW'(1);
            if (comb_fire) begin
                d1 <= i3;
                d2 <= c1;
                d3 <= c2;
                y  <= y_nxt;
            end
        end
    end

    // Arithmetic shift of the accumulator is just its top Wout bits.
    assign dc   = acc[Wout+K-1:K];
    assign diff = {y[Wout-1], y} - {dc[Wout-1], dc};

    // Clamp the DC-corrected sample back into the output range.
    always_comb begin
        diff_sat = diff[Wout-1:0];
        if (diff[Wout] != diff[Wout-1]) diff_sat = diff[Wout] ? OUT_MIN : OUT_MAX;
    end

    // DC tracker and output register; the tracker runs even when correction is bypassed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            o_data  <= '0;
            o_level <= '0;
            val_out <= 1'b0;
        end else begin
            val_out <= y_vld;
            if (y_vld) begin
                acc     <= acc + {{K{y[Wout-1]}}, y} - {{K{dc[Wout-1]}}, dc};
                o_level <= dc;
                o_data  <= c_dc_en ? diff_sat : y;
            end
        end
    end

endmodule

// File: doc/am_envelope_demod.md
Name: am_envelope_demod

Overview:
- Receive-side counterpart of the FM/AM modulation datapath. It takes the 14-bit modulated sample stream at full rate, recovers the AM envelope, and decimates it back to the modulating-signal rate.
- Processing chain: full-wave rectifier, then a 3-stage CIC decimator, then an optional first-order DC-removal stage.
- Sits between the ADC/loopback of the modulator's 14-bit output and the baseband consumer. It also exports the envelope mean for level monitoring.

Parameters:
- R, 16, decimation factor; must be a power of 2, at least 2.
- N, 3, number of CIC stages; fixed at 3 for this block. Differential delay M = 1.
- Win, 14, input sample width (signed).
- Wacc, 26, CIC register width. Equals Win + N*log2(R).
- Wout, 16, output width (signed).
- K, 8, DC-removal time-constant shift.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_data  in  14  signed modulated sample
- val_in  in  1  i_data valid; may be deasserted for any number of cycles
- c_dc_en  in  1  1 = DC removal applied to o_data; 0 = raw CIC output
- o_data  out  16  signed demodulated envelope
- o_level  out  16  signed DC estimate (envelope mean)
- val_out  out  1  one-cycle pulse per decimated output sample

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst).
  - Reset asserted clears: rectifier register, all valid pipeline bits, integrators, comb delays, decimation counter, DC accumulator, o_data, o_level and val_out, all to 0.
  - Reset mid-operation discards all in-flight samples. No val_out is produced from pre-reset data.
- Valid pipeline: one valid bit travels with each stage. A stage updates only when its incoming valid is 1; otherwise it holds.
- Stage 1 (rectifier), 1 register:
  - r = |i_data|.
  - -8192 saturates to +8191.
  - r is zero-extended to Wacc.
- Stages 2-4 (integrators), one register each:
  - I1 += r; I2 += I1; I3 += I2.
  - Modular Wacc-bit arithmetic; wrap-around is required and is not an error.
- Decimation counter:
  - Runs 0..R-1 and increments on each stage-4 valid; wraps R-1 to 0.
  - When stage-4 valid and count == R-1, the comb stage fires.
- Stage 5 (comb), 1 register, Wacc modular arithmetic:
  - c1 = I3 - d1; c2 = c1 - d2; c3 = c2 - d3.
  - Then d1 <= I3, d2 <= c1, d3 <= c2.
  - y = c3[Wacc-1 : Wacc-Wout], i.e. truncation, gain R^N / 2^(Wacc-Wout).
  - For the defaults: gain 4096/1024 = 4; y range 0..32764.
- Stage 6 (DC removal), 1 register, fires on the stage-5 valid:
  - dc = acc >>> K, where acc is a signed (Wout+K)-bit accumulator.
  - acc <= acc + y - dc.
  - o_level <= dc.
  - o_data <= c_dc_en ? sat16(y - dc) : y.
  - val_out pulses high for exactly one cycle.
  - The acc update occurs regardless of c_dc_en.
- Latency:
  - val_out rises on the 6th rising edge after the edge that samples the R-th valid input, counted since reset.
  - Subsequent outputs follow after every further R valid inputs.
  - With val_in held high, val_out period = R cycles.
- Outputs hold their value between val_out pulses.
- c_dc_en is sampled only when stage 6 fires. Toggling it mid-stream affects the next output only and never clears acc.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with random input activity. Required: o_data = o_level = 0 and val_out = 0 immediately. After release with val_in = 1 continuous, the first val_out occurs exactly R + 6 edges later.
2. Rectification, constant input, c_dc_en = 0, val_in = 1 continuous:
   - i_data = +4096: after 3 outputs, o_data = 16384 every output, val_out every 16 cycles.
   - i_data = -4096: identical result.
   - i_data = -8192: o_data = 32764.
3. Gapped valid: i_data = +4096 with val_in toggling every cycle. Required: val_out period 32 cycles, values identical to scenario 2. Data presented while val_in = 0 must be ignored.
4. Integrator wrap: run i_data = +8191 continuously for more than 2^14 outputs, so the integrators wrap many times. Required: o_data stays 32764 with no glitch.
5. DC removal: i_data = +4096 continuous, c_dc_en = 1. Required: o_level rises monotonically toward 16384 and reaches at least 16380 within 3000 outputs. o_data decays from 16384 to |o_data| ≤ 4. Toggling c_dc_en to 0 makes the next o_data = 16384.
6. AM tone: carrier with period 4 samples and amplitude 4096 ± 2048, envelope with period 64 outputs, c_dc_en = 1. Required: o_data is a sinusoid with period 64 outputs and a peak-to-peak amplitude of about 8192 × 2/π × 2 (±10%), and its mean is within ±64 of 0.
